// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback and the multi-port register file.
// clk and rst stay plain ports on the register file itself.
interface regfile_mp_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              clr;
  logic              busy;
  logic              we_a;
  logic [ADDR_W-1:0] waddr_a;
  logic [WIDTH-1:0]  wdata_a;
  logic              we_b;
  logic [ADDR_W-1:0] waddr_b;
  logic [WIDTH-1:0]  wdata_b;
  logic [ADDR_W-1:0] raddr1;
  logic [WIDTH-1:0]  rdata1;
  logic [ADDR_W-1:0] raddr2;
  logic [WIDTH-1:0]  rdata2;

  modport master (
    output clr, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, raddr1, raddr2,
    input  busy, rdata1, rdata2
  );

  modport slave (
    input  clr, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, raddr1, raddr2,
    output busy, rdata1, rdata2
  );
endinterface

// File: rtl/regfile_mp.sv
// Two-write / two-read register file with optional zero entry, optional
// write-to-read bypass and a one-entry-per-cycle clear engine.
module regfile_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              idle;
  logic              wr_a, wr_b;
  logic [ADDR_W-1:0] raddr [2];
  logic [WIDTH-1:0]  rdata [2];

  // Address maps to a real, writable/readable entry (not out of range, not the zero entry).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X) && !(ZERO_REG && (a == '0));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // clr restarts the clear sequence from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.clr) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
    end else if (state_q == S_CLEAR) begin
      if (cnt_q == LAST_IDX) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  assign idle     = (state_q == S_IDLE);
  assign bus.busy = (state_q == S_CLEAR);
  assign wr_a     = bus.we_a && addr_ok(bus.waddr_a);
  assign wr_b     = bus.we_b && addr_ok(bus.waddr_b);

  // Port B is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!rst && !bus.clr) begin
      if (state_q == S_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else begin
        if (wr_a) mem_q[bus.waddr_a] <= bus.wdata_a;
        if (wr_b) mem_q[bus.waddr_b] <= bus.wdata_b;
      end
    end
  end

  assign raddr[0] = bus.raddr1;
  assign raddr[1] = bus.raddr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      if (idle && addr_ok(raddr[p])) begin
        if (BYPASS && wr_b && (bus.waddr_b == raddr[p])) begin
          rdata[p] = bus.wdata_b;
        end else if (BYPASS && wr_a && (bus.waddr_a == raddr[p])) begin
          rdata[p] = bus.wdata_a;
        end else begin
          rdata[p] = mem_q[raddr[p]];
        end
      end
    end
  end

  assign bus.rdata1 = rdata[0];
  assign bus.rdata2 = rdata[1];
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed check of regfile_mp (bypass and non-bypass builds)
// against an array-based reference model.
module tb_regfile_mp;
  localparam int unsigned DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        we_a, we_b;
  logic [4:0]  waddr_a, waddr_b, raddr1, raddr2;
  logic [31:0] wdata_a, wdata_b;

  regfile_mp_if #(.WIDTH(32), .ADDR_W(5)) bus_byp ();
  regfile_mp_if #(.WIDTH(32), .ADDR_W(5)) bus_nb ();

  assign bus_byp.clr = clr;       assign bus_nb.clr = clr;
  assign bus_byp.we_a = we_a;     assign bus_nb.we_a = we_a;
  assign bus_byp.waddr_a = waddr_a; assign bus_nb.waddr_a = waddr_a;
  assign bus_byp.wdata_a = wdata_a; assign bus_nb.wdata_a = wdata_a;
  assign bus_byp.we_b = we_b;     assign bus_nb.we_b = we_b;
  assign bus_byp.waddr_b = waddr_b; assign bus_nb.waddr_b = waddr_b;
  assign bus_byp.wdata_b = wdata_b; assign bus_nb.wdata_b = wdata_b;
  assign bus_byp.raddr1 = raddr1; assign bus_nb.raddr1 = raddr1;
  assign bus_byp.raddr2 = raddr2; assign bus_nb.raddr2 = raddr2;

  regfile_mp #(.WIDTH(32), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .rst(rst), .bus(bus_byp)
  );
  regfile_mp #(.WIDTH(32), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .bus(bus_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: contents as software sees them, plus edges left until the clear finishes.
  logic [31:0] ref_mem [DEPTH];
  int          busy_left = DEPTH;
  int          n_total = 0;
  int          n_pass  = 0;
  bit          chk_en  = 1'b0;
  string       phase   = "reset";

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (busy_left > 0 || ra == 5'd0) return 32'h0;
    if (byp && we_b && waddr_b == ra) return wdata_b;
    if (byp && we_a && waddr_a == ra) return wdata_a;
    return ref_mem[ra];
  endfunction

  // Check outputs against current inputs, take one edge, update model, return at negedge.
  task automatic step();
    #1;
    if (chk_en) begin
      check_eq("busy_byp", 32'(bus_byp.busy), 32'(busy_left > 0));
      check_eq("busy_nb",  32'(bus_nb.busy),  32'(busy_left > 0));
      check_eq("rd1_byp", bus_byp.rdata1, exp_rd(raddr1, 1'b1));
      check_eq("rd2_byp", bus_byp.rdata2, exp_rd(raddr2, 1'b1));
      check_eq("rd1_nb",  bus_nb.rdata1,  exp_rd(raddr1, 1'b0));
      check_eq("rd2_nb",  bus_nb.rdata2,  exp_rd(raddr2, 1'b0));
    end
    @(posedge clk);
    if (rst || clr) begin
      busy_left = DEPTH;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (we_a && waddr_a != 5'd0) ref_mem[waddr_a] = wdata_a;
      if (we_b && waddr_b != 5'd0) ref_mem[waddr_b] = wdata_b;
    end
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic quiet();
    clr = 1'b0; we_a = 1'b0; we_b = 1'b0;
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (bus_byp.busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    check_eq(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    rst = 1'b1; quiet();
    waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; raddr1 = '0; raddr2 = '0;

    // Reset held 3 cycles, then the clear runs for exactly DEPTH edges.
    repeat (3) step();
    rst = 1'b0; raddr1 = 5'd3; raddr2 = 5'd31;
    count_busy("busy_edges_rst");
    phase = "readall";
    for (int i = 0; i < int'(DEPTH); i++) begin
      raddr1 = 5'(i); raddr2 = 5'(DEPTH - 1 - i);
      step();
    end

    phase = "write_a";
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; raddr1 = 5'd1; raddr2 = 5'd5;
    #1 check_eq("bypass_same_cycle", bus_byp.rdata2, 32'hDEADBEEF);
    step();
    quiet(); raddr1 = 5'd5;
    #1 check_eq("stored_next_cycle", bus_byp.rdata1, 32'hDEADBEEF);
    step();

    phase = "collide";
    we_a = 1'b1; we_b = 1'b1; waddr_a = 5'd7; waddr_b = 5'd7;
    wdata_a = 32'h1; wdata_b = 32'h2; raddr1 = 5'd7; raddr2 = 5'd7;
    #1 check_eq("bypass_b_wins", bus_byp.rdata1, 32'h2);
    step();
    quiet();
    #1 check_eq("stored_b_wins", bus_nb.rdata2, 32'h2);
    step();

    phase = "zero_reg";
    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF; raddr1 = 5'd0;
    step();
    quiet();
    step();

    phase = "nobypass";
    we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h1111; step();
    we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'hA5A5; raddr1 = 5'd9;
    #1 check_eq("nb_old_value", bus_nb.rdata1, 32'h1111);
    step();
    quiet();
    #1 check_eq("nb_new_value", bus_nb.rdata1, 32'hA5A5);
    step();

    phase = "clr_restart";
    for (int i = 1; i < int'(DEPTH); i++) begin
      we_b = 1'b1; waddr_b = 5'(i); wdata_b = 32'(i * 32'h0101_0101); raddr1 = 5'(i);
      step();
    end
    quiet(); clr = 1'b1; step();
    clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      we_a = 1'b1; waddr_a = 5'($urandom_range(1, 31)); wdata_a = $urandom;
      raddr1 = waddr_a; raddr2 = 5'($urandom_range(0, 31));
      step();
    end
    quiet(); clr = 1'b1; step();
    clr = 1'b0; we_a = 1'b1; waddr_a = 5'd12; wdata_a = 32'hBAD0_0BAD;
    count_busy("busy_edges_clr");
    quiet();
    for (int i = 0; i < int'(DEPTH); i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i ^ 5);
      step();
    end

    phase = "random";
    for (int c = 0; c < 3000; c++) begin
      clr  = ($urandom_range(0, 199) == 0);
      we_a = $urandom_range(0, 1) == 1;
      we_b = $urandom_range(0, 1) == 1;
      waddr_a = 5'($urandom_range(0, 31));
      waddr_b = ($urandom_range(0, 3) == 0) ? waddr_a : 5'($urandom_range(0, 31));
      wdata_a = $urandom;
      wdata_b = $urandom;
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr_a : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 2) == 0) ? waddr_b : 5'($urandom_range(0, 31));
      step();
    end
    quiet();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
